scan_decoder: RTL

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 84 ++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// One-hot output decoder with a direct mode (Y = 1<<A) and an auto-scan mode.
// In auto-scan, each output stays active for DWELL cycles. All outputs are registered.
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      A,
  input  logic                  E,
  input  logic                  mode,
  output logic [(2**SEL_W)-1:0] Y,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int N     = 2 ** SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [N-1:0] dec;
    dec      = '0;
    dec[sel] = 1'b1;
    return dec;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Y         <= '0;
      idx       <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (!E) begin
      // idx keeps the last active index so software can see where the scan stopped
      state     <= IDLE;
      Y         <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (!mode) begin
      state     <= DIRECT;
      Y         <= decode(A);
      idx       <= A;
      valid     <= 1'b1;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (state != SCAN) begin
      // Any entry into scan restarts at index 0 with a full dwell
      state     <= SCAN;
      Y         <= decode('0);
      idx       <= '0;
      valid     <= 1'b1;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (dwell_cnt == CNT_LAST) begin
      state     <= SCAN;
      Y         <= decode(idx + SEL_W'(1));
      idx       <= idx + SEL_W'(1);
      valid     <= 1'b1;
      wrap      <= (idx == IDX_LAST);
      dwell_cnt <= '0;
    end else begin
      state     <= SCAN;
      valid     <= 1'b1;
      wrap      <= 1'b0;
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

endmodule
